fmul_norm_round: RTL and testbench

- Two-stage pipelined post-processor for the FP32 multiply datapath.
- Consumes the raw 64-bit unsigned significand product from the 32x32 Booth multiplier, plus sign, exponent sum and special-case flags from the operand-unpack stage.
- Normalizes (leading-zero shift, gradual underflow), rounds per IEEE-754/RISC-V rounding mode, and packs the FP32 result with exception flags.
- Uses a valid/ready handshake on both sides.

---
 rtl/fmul_norm_round.sv | 199 +++++++++++++++++++
 tb/tb_fmul_norm_round.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_norm_round.sv
// rtl/fmul_norm_round.sv - FP32 multiply normalize/round/pack two-stage pipeline
module fmul_norm_round #(
  parameter int EXP_W = 10,
  parameter int LZC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_prod,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp_sum,
  input  logic             in_nan,
  input  logic             in_nv,
  input  logic             in_inf,
  input  logic             in_zero,
  input  logic [2:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_fflags
);

  // One extra bit so exp_sum + 1 - lz never wraps.
  localparam int E_W = EXP_W + 1;

  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(255);
  localparam logic signed [E_W-1:0] SH_MAX = E_W'(49);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Handshake
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Upper product bits are always zero from the multiplier.
  logic unused_prod_hi;
  assign unused_prod_hi = ^in_prod[63:48];

  // Stage 1 combinational: normalize and denormalize
  logic [LZC_W-1:0]      lz;
  logic [47:0]           m_norm;
  logic signed [E_W-1:0] exp_ext;
  logic signed [E_W-1:0] lz_ext;
  logic signed [E_W-1:0] e_norm;
  logic signed [E_W-1:0] sh_full;
  logic [LZC_W-1:0]      sh;
  logic [47:0]           m_d;
  logic signed [E_W-1:0] e_d;
  logic                  sticky_d;

  // Leading-zero count over the 48-bit product; highest set bit wins.
  always_comb begin
    lz = LZC_W'(48);
    for (int i = 0; i < 48; i++) begin
      if (in_prod[i]) lz = LZC_W'(47 - i);
    end
  end

  assign m_norm  = in_prod[47:0] << lz;
  assign exp_ext = {in_exp_sum[EXP_W-1], in_exp_sum};
  assign lz_ext  = {{(E_W-LZC_W){1'b0}}, lz};
  assign e_norm  = exp_ext + E_ONE - lz_ext;

  // Gradual underflow: shift right into the subnormal range, keep a sticky.
  always_comb begin
    m_d      = m_norm;
    e_d      = e_norm;
    sticky_d = 1'b0;
    sh_full  = '0;
    sh       = '0;
    if (e_norm < E_ONE) begin
      sh_full  = E_ONE - e_norm;
      sh       = (sh_full > SH_MAX) ? LZC_W'(49) : sh_full[LZC_W-1:0];
      m_d      = m_norm >> sh;
      sticky_d = |(m_norm & ~({48{1'b1}} << sh));
      e_d      = '0;
    end
  end

  // Stage 1 registers
  logic [47:0]           s1_m;
  logic signed [E_W-1:0] s1_e;
  logic                  s1_sticky;
  logic                  s1_sign;
  logic [2:0]            s1_rm;
  logic                  s1_nan;
  logic                  s1_nv;
  logic                  s1_inf;
  logic                  s1_zero;

  // Capture normalized operand whenever stage 1 may advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_m      <= '0;
      s1_e      <= '0;
      s1_sticky <= 1'b0;
      s1_sign   <= 1'b0;
      s1_rm     <= '0;
      s1_nan    <= 1'b0;
      s1_nv     <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_m      <= m_d;
        s1_e      <= e_d;
        s1_sticky <= sticky_d;
        s1_sign   <= in_sign;
        s1_rm     <= in_rm;
        s1_nan    <= in_nan;
        s1_nv     <= in_nv;
        s1_inf    <= in_inf;
        s1_zero   <= in_zero | ~|in_prod[47:0];
      end
    end
  end

  // Stage 2 combinational: round, overflow, specials, pack
  logic [23:0]           q;
  logic                  g;
  logic                  st;
  logic                  inexact;
  logic                  inc;
  logic [24:0]           q_r;
  logic signed [E_W-1:0] e_r;
  logic                  ovf_inf;
  logic [31:0]           res_d;
  logic [4:0]            flags_d;

  // Rounding increment, carry renormalization and result selection.
  always_comb begin
    q       = s1_m[47:24];
    g       = s1_m[23];
    st      = |s1_m[22:0] | s1_sticky;
    inexact = g | st;
    case (s1_rm)
      RM_RNE:  inc = g & (st | q[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign & inexact;
      RM_RUP:  inc = ~s1_sign & inexact;
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
    q_r = {1'b0, q} + {24'b0, inc};
    e_r = s1_e;
    if (q_r[24]) begin
      q_r = q_r >> 1;
      e_r = e_r + E_ONE;
    end
    if ((s1_e == '0) && q_r[23]) e_r = E_ONE;
    ovf_inf = (s1_rm == RM_RNE) || (s1_rm == RM_RMM) ||
              ((s1_rm == RM_RUP) && !s1_sign) ||
              ((s1_rm == RM_RDN) && s1_sign);
    res_d   = {s1_sign, e_r[7:0], q_r[22:0]};
    flags_d = {3'b000, (s1_e == '0) & inexact, inexact};
    if (s1_nan) begin
      res_d   = 32'h7FC0_0000;
      flags_d = {s1_nv, 4'b0000};
    end else if (s1_inf) begin
      res_d   = {s1_sign, 8'hFF, 23'h0};
      flags_d = 5'b00000;
    end else if (s1_zero) begin
      res_d   = {s1_sign, 31'h0};
      flags_d = 5'b00000;
    end else if (e_r >= E_MAX) begin
      res_d   = ovf_inf ? {s1_sign, 8'hFF, 23'h0} : {s1_sign, 8'hFE, 23'h7F_FFFF};
      flags_d = 5'b00101;
    end
  end

  // Output registers; data held while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_fflags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_fflags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// tb/tb_fmul_norm_round.sv - table-driven scoreboard bench for fmul_norm_round
module tb_fmul_norm_round;

  typedef struct {
    string       name;
    logic [63:0] prod;
    logic        sign;
    logic [9:0]  exp_sum;
    logic        nan;
    logic        nv;
    logic        inf;
    logic        zero;
    logic [2:0]  rm;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_prod = '0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp_sum = '0;
  logic        in_nan = 1'b0;
  logic        in_nv = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_zero = 1'b0;
  logic [2:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  logic        man_rdy = 1'b1;
  logic        bp_rdy = 1'b1;
  logic        bp_on = 1'b0;
  assign out_ready = bp_on ? bp_rdy : man_rdy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[$];
  exp_t mon_e;
  logic        hold_v = 1'b0;
  logic [31:0] hold_res;
  logic [4:0]  hold_fl;

  fmul_norm_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prod    (in_prod),
    .in_sign    (in_sign),
    .in_exp_sum (in_exp_sum),
    .in_nan     (in_nan),
    .in_nv      (in_nv),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_fflags (out_fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic [63:0] p, input logic s, input int e,
                     input logic [3:0] spc, input logic [2:0] rm,
                     input logic [31:0] r, input logic [4:0] f);
    vec_t v;
    v.name    = n;
    v.prod    = p;
    v.sign    = s;
    v.exp_sum = 10'(e);
    {v.nan, v.nv, v.inf, v.zero} = spc;
    v.rm      = rm;
    v.exp_res = r;
    v.exp_fl  = f;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_prod    = v.prod;
    in_sign    = v.sign;
    in_exp_sum = v.exp_sum;
    in_nan     = v.nan;
    in_nv      = v.nv;
    in_inf     = v.inf;
    in_zero    = v.zero;
    in_rm      = v.rm;
    in_valid   = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{v.name, v.exp_res, v.exp_fl});
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s_accept: in_ready stayed 0 want 1", v.name);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding want 0", sb.size());
    end
    @(negedge clk);
  endtask

  // Random backpressure source
  always @(posedge clk) begin
    #1;
    bp_rdy = 1'($urandom_range(0, 1));
  end

  // Scoreboard pop on each output transfer, plus hold-while-stalled check
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        check("stall_hold_res", out_result, hold_res);
        check("stall_hold_fl", {27'b0, out_fflags}, {27'b0, hold_fl});
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_result;
      hold_fl  = out_fflags;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h want none", out_result);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_res"}, out_result, mon_e.res);
          check({mon_e.name, "_fl"}, {27'b0, out_fflags}, {27'b0, mon_e.fl});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;

    add("mul15",       64'h0000_9000_0000_0000, 0,  127, 4'b0000, RNE, 32'h4010_0000, 5'h00);
    add("ovf_rne",     64'h0000_9000_0000_0000, 0,  254, 4'b0000, RNE, 32'h7F80_0000, 5'h05);
    add("ovf_rtz",     64'h0000_9000_0000_0000, 0,  254, 4'b0000, RTZ, 32'h7F7F_FFFF, 5'h05);
    add("ovf_rdn_neg", 64'h0000_9000_0000_0000, 1,  254, 4'b0000, RDN, 32'hFF80_0000, 5'h05);
    add("ovf_rdn_pos", 64'h0000_9000_0000_0000, 0,  254, 4'b0000, RDN, 32'h7F7F_FFFF, 5'h05);
    add("ovf_rup_neg", 64'h0000_9000_0000_0000, 1,  254, 4'b0000, RUP, 32'hFF7F_FFFF, 5'h05);
    add("ovf_rmm",     64'h0000_9000_0000_0000, 0,  254, 4'b0000, RMM, 32'h7F80_0000, 5'h05);
    add("tie_rne",     64'h0000_8000_0180_0000, 0,  127, 4'b0000, RNE, 32'h4000_0002, 5'h01);
    add("tie_rtz",     64'h0000_8000_0180_0000, 0,  127, 4'b0000, RTZ, 32'h4000_0001, 5'h01);
    add("tie_rdn_neg", 64'h0000_8000_0180_0000, 1,  127, 4'b0000, RDN, 32'hC000_0002, 5'h01);
    add("even_rne",    64'h0000_8000_0080_0000, 0,  127, 4'b0000, RNE, 32'h4000_0000, 5'h01);
    add("even_rmm",    64'h0000_8000_0080_0000, 0,  127, 4'b0000, RMM, 32'h4000_0001, 5'h01);
    add("carry",       64'h0000_FFFF_FF80_0000, 0,  127, 4'b0000, RNE, 32'h4080_0000, 5'h01);
    add("one",         64'h0000_4000_0000_0000, 0,  127, 4'b0000, RNE, 32'h3F80_0000, 5'h00);
    add("sub",         64'h0000_4000_0000_0000, 0,   -1, 4'b0000, RNE, 32'h0020_0000, 5'h00);
    add("sub_stk_rne", 64'h0000_4000_0000_0001, 0,   -1, 4'b0000, RNE, 32'h0020_0000, 5'h03);
    add("sub_stk_rup", 64'h0000_4000_0000_0001, 0,   -1, 4'b0000, RUP, 32'h0020_0001, 5'h03);
    add("sub_to_norm", 64'h0000_FFFF_FF00_0000, 0,   -1, 4'b0000, RNE, 32'h0080_0000, 5'h03);
    add("deep_rup",    64'h0000_4000_0000_0000, 0, -200, 4'b0000, RUP, 32'h0000_0001, 5'h03);
    add("deep_rne",    64'h0000_4000_0000_0000, 0, -200, 4'b0000, RNE, 32'h0000_0000, 5'h03);
    add("nan_nv",      64'h0000_9000_0000_0000, 0,  127, 4'b1100, RNE, 32'h7FC0_0000, 5'h10);
    add("nan_inf",     64'h0000_9000_0000_0000, 1,  127, 4'b1010, RNE, 32'h7FC0_0000, 5'h00);
    add("inf_neg",     64'h0000_9000_0000_0000, 1,  127, 4'b0010, RNE, 32'hFF80_0000, 5'h00);
    add("zero_neg",    64'h0000_9000_0000_0000, 1,  127, 4'b0001, RNE, 32'h8000_0000, 5'h00);
    add("prod_zero",   64'h0000_0000_0000_0000, 0,  127, 4'b0000, RNE, 32'h0000_0000, 5'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_fflags", {27'b0, out_fflags}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Latency of a single transaction
    drive(vecs[0]);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'h1);
    wait_drain();

    // Full table back-to-back, downstream always ready
    @(posedge clk);
    #1;
    foreach (vecs[i]) drive(vecs[i]);
    in_valid = 1'b0;
    wait_drain();

    // Full table again under random backpressure
    @(posedge clk);
    #1;
    bp_on = 1'b1;
    foreach (vecs[i]) drive(vecs[i]);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bp_on = 1'b0;
    wait_drain();

    // Four back-to-back inputs against a 3+ cycle output stall
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    fork
      begin
        drive(vecs[7]);
        drive(vecs[14]);
        drive(vecs[16]);
        drive(vecs[12]);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_in_ready", {31'b0, in_ready}, 32'h0);
        check("stall_out_valid", {31'b0, out_valid}, 32'h1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
      end
    join
    wait_drain();

    // Asynchronous reset with results in flight
    @(posedge clk);
    #1;
    drive(vecs[1]);
    drive(vecs[8]);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_stale", 32'(seen), 32'h0);
    check("rst_release_in_ready", {31'b0, in_ready}, 32'h1);

    // Recovery after reset
    @(posedge clk);
    #1;
    drive(vecs[20]);
    drive(vecs[17]);
    in_valid = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
